// File: rtl/block_mac_2x2_if.sv
// CU <-> block MAC handshake bundle: start request, A/B operand block, C result block,
// completion strobe and busy flag.
interface block_mac_2x2_if #(
  parameter int data_w = 32
);
  logic              start_mac;
  logic [data_w-1:0] a_11, a_12, a_21, a_22;
  logic [data_w-1:0] b_11, b_12, b_21, b_22;
  logic [data_w-1:0] c_11, c_12, c_21, c_22;
  logic              done_mac;
  logic              busy;

  modport master (
    output start_mac,
    output a_11, a_12, a_21, a_22,
    output b_11, b_12, b_21, b_22,
    input  c_11, c_12, c_21, c_22,
    input  done_mac,
    input  busy
  );

  modport slave (
    input  start_mac,
    input  a_11, a_12, a_21, a_22,
    input  b_11, b_12, b_21, b_22,
    output c_11, c_12, c_21, c_22,
    output done_mac,
    output busy
  );
endinterface

// File: rtl/block_mac_2x2.sv
// 2x2 block multiply C = A x B using one shared registered multiplier and an adder;
// eight product steps, done_mac strobes 9 cycles after the accepting start edge.
module block_mac_2x2 #(
  parameter int data_w = 32
) (
  input  logic          clk,
  input  logic          rst,
  block_mac_2x2_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t            state;
  logic              start_q;
  logic [2:0]        step;
  logic              tail;
  logic [data_w-1:0] prod;
  logic [2:0]        prod_step;
  logic              prod_vld;
  logic              done;
  logic              busy;
  logic [data_w-1:0] a_r [0:3];
  logic [data_w-1:0] b_r [0:3];
  logic [data_w-1:0] c_r [0:3];
  logic [data_w-1:0] a_sel;
  logic [data_w-1:0] b_sel;

  // Flat index order: 0=x11 1=x12 2=x21 3=x22. Step s uses A row s[2], column s[0]
  // and B row s[0], column s[1]; its destination is c[s[2:1]].
  always_comb begin
    a_sel = a_r[{step[2], step[0]}];
    b_sel = b_r[{step[0], step[1]}];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      step      <= '0;
      tail      <= 1'b0;
      prod      <= '0;
      prod_step <= '0;
      prod_vld  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        a_r[i] <= '0;
        b_r[i] <= '0;
        c_r[i] <= '0;
      end
    end else begin
      start_q <= bus.start_mac;
      case (state)
        IDLE: begin
          if (bus.start_mac && !start_q) begin
            a_r[0]   <= bus.a_11;
            a_r[1]   <= bus.a_12;
            a_r[2]   <= bus.a_21;
            a_r[3]   <= bus.a_22;
            b_r[0]   <= bus.b_11;
            b_r[1]   <= bus.b_12;
            b_r[2]   <= bus.b_21;
            b_r[3]   <= bus.b_22;
            for (int unsigned i = 0; i < 4; i++) c_r[i] <= '0;
            step     <= '0;
            tail     <= 1'b0;
            prod_vld <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          // Issue stage: one product per cycle until step 7 has been registered.
          if (!tail) begin
            prod      <= a_sel * b_sel;
            prod_step <= step;
            prod_vld  <= 1'b1;
            if (step == 3'd7) tail <= 1'b1;
            else              step <= step + 3'd1;
          end
          // Accumulate stage trails issue by one cycle.
          if (prod_vld)
            c_r[prod_step[2:1]] <= c_r[prod_step[2:1]] + prod;
          if (tail) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.c_11     = c_r[0];
  assign bus.c_12     = c_r[1];
  assign bus.c_21     = c_r[2];
  assign bus.c_22     = c_r[3];
  assign bus.done_mac = done;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_block_mac_2x2.sv
// Bench for block_mac_2x2: directed handshake/timing cases plus randomized operands
// compared against a plain matrix-product model.
module tb_block_mac_2x2;
    localparam int data_w = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    block_mac_2x2_if #(.data_w(data_w)) bus ();
    block_mac_2x2 #(.data_w(data_w)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] ta [4];
    logic [31:0] tb_ [4];
    logic [31:0] ec [4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // C[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 2^32
    task automatic model();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                longint unsigned s = 0;
                for (int k = 0; k < 2; k++) begin
                    longint unsigned x = ta[i*2+k];
                    longint unsigned y = tb_[k*2+j];
                    s += x * y;
                end
                ec[i*2+j] = s[31:0];
            end
    endtask

    task automatic drive_ops();
        bus.a_11 = ta[0];  bus.a_12 = ta[1];  bus.a_21 = ta[2];  bus.a_22 = ta[3];
        bus.b_11 = tb_[0]; bus.b_12 = tb_[1]; bus.b_21 = tb_[2]; bus.b_22 = tb_[3];
    endtask

    task automatic drive_nines();
        bus.a_11 = 9; bus.a_12 = 9; bus.a_21 = 9; bus.a_22 = 9;
        bus.b_11 = 9; bus.b_12 = 9; bus.b_21 = 9; bus.b_22 = 9;
    endtask

    task automatic check_c(input string tag);
        check({tag, "_c11"}, bus.c_11, ec[0]);
        check({tag, "_c12"}, bus.c_12, ec[1]);
        check({tag, "_c21"}, bus.c_21, ec[2]);
        check({tag, "_c22"}, bus.c_22, ec[3]);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            ta[i]  = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 15);
            tb_[i] = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 15);
        end
    endtask

    // Called at a negedge with start_mac low; start held for 'hold' accepting-side edges.
    task automatic run_op(input int hold, input int chg_at, input string tag);
        int lat;
        model();
        drive_ops();
        bus.start_mac = 1'b1;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k + 1 == hold) bus.start_mac = 1'b0;
            if (k == chg_at) drive_nines();
            if (k == 0) check({tag, "_busy0"}, bus.busy, 1);
            if (bus.done_mac) begin
                lat = k;
                break;
            end
        end
        bus.start_mac = 1'b0;
        check({tag, "_lat"}, lat, 9);
        check({tag, "_busy_done"}, bus.busy, 1);
        check_c(tag);
        @(negedge clk);
        check({tag, "_done_drop"}, bus.done_mac, 0);
        check({tag, "_busy_drop"}, bus.busy, 0);
    endtask

    initial begin
        int dones;
        int lat;
        rst = 1'b0;
        bus.start_mac = 1'b0;
        for (int i = 0; i < 4; i++) begin ta[i] = 0; tb_[i] = 0; end
        drive_ops();
        #12;
        for (int i = 0; i < 4; i++) ec[i] = 0;
        check_c("reset");
        check("reset_done", bus.done_mac, 0);
        check("reset_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic example, single-cycle start pulse
        ta = '{1, 2, 3, 4};
        tb_ = '{5, 6, 7, 8};
        run_op(1, -1, "basic");
        check("basic_c11_abs", bus.c_11, 19);
        check("basic_c22_abs", bus.c_22, 50);

        // Start held two cycles: one result, then outputs hold while idle
        run_op(2, -1, "hold2");
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done_mac) dones++;
        end
        check("hold2_extra_done", dones, 0);
        check("hold2_hold_c11", bus.c_11, 19);
        check("hold2_hold_c12", bus.c_12, 22);
        check("hold2_hold_c21", bus.c_21, 43);
        check("hold2_hold_c22", bus.c_22, 50);

        // Modulo wrap of a single product
        ta = '{32'h0001_0000, 0, 0, 0};
        tb_ = '{32'h0001_0000, 0, 0, 0};
        run_op(1, -1, "wrap0");
        check("wrap0_c11_abs", bus.c_11, 0);
        ta = '{32'hFFFF_FFFF, 0, 0, 0};
        tb_ = '{32'hFFFF_FFFF, 0, 0, 0};
        run_op(1, -1, "wrap1");
        check("wrap1_c11_abs", bus.c_11, 1);

        // Rise while busy, held through DONE: discarded, never replayed
        rand_ops();
        model();
        drive_ops();
        bus.start_mac = 1'b1;
        dones = 0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) bus.start_mac = 1'b0;
            if (k == 3) bus.start_mac = 1'b1;
            if (bus.done_mac) begin
                dones++;
                if (lat < 0) begin
                    lat = k;
                    check_c("busyrise");
                end
            end
        end
        check("busyrise_lat", lat, 9);
        check("busyrise_dones", dones, 1);
        bus.start_mac = 1'b0;
        @(negedge clk);
        rand_ops();
        run_op(1, -1, "busyrise_next");

        // Operands changed right after accept must not matter
        rand_ops();
        run_op(1, 0, "chg");

        // Asynchronous reset mid-operation
        rand_ops();
        drive_ops();
        bus.start_mac = 1'b1;
        @(negedge clk);
        bus.start_mac = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) ec[i] = 0;
        check_c("rst_mid");
        check("rst_mid_done", bus.done_mac, 0);
        check("rst_mid_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done_mac) dones++;
        end
        check("rst_mid_no_done", dones, 0);
        rand_ops();
        run_op(1, -1, "rst_next");

        // Randomized operands and start hold lengths
        for (int n = 0; n < 15; n++) begin
            rand_ops();
            run_op($urandom_range(1, 3), -1, "rnd");
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
